datapath2_seq_ctrl: RTL and testbench

//  Sequencer for the 3-register 4-bit datapath (M0/M1/M2 -> R0/R1/R2, SW1 load select, Cin).
//  On START it runs one load cycle, then ITER_CNT compute cycles. Each compute cycle writes one

---
 rtl/datapath2_seq_ctrl_pkg.sv | 27 ++
 rtl/datapath2_seq_ctrl_rot3_ptr.sv | 27 ++
 rtl/datapath2_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_datapath2_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/datapath2_seq_ctrl_pkg.sv
// Shared definitions for the datapath2 sequencer: state encoding, write-enable
// constants and the pointer-to-write-enable decode.
package datapath2_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_R0   = 3'b001;
  localparam logic [2:0] WE_R1   = 3'b010;
  localparam logic [2:0] WE_R2   = 3'b100;
  localparam logic [2:0] WE_ALL  = 3'b111;

  function automatic logic [2:0] ptr_to_we(input logic [1:0] ptr);
    case (ptr)
      2'd0:    return WE_R0;
      2'd1:    return WE_R1;
      2'd2:    return WE_R2;
      default: return WE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/datapath2_seq_ctrl_rot3_ptr.sv
// Mod-3 rotating register pointer (R0,R1,R2,R0,...) with synchronous clear,
// advance enable and one-hot write-enable decode.
module datapath2_seq_ctrl_rot3_ptr
  import datapath2_seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  output logic [2:0] onehot
);

  logic [1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (clr) begin
      ptr <= 2'd0;
    end else if (adv) begin
      ptr <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    end
  end

  assign onehot = ptr_to_we(ptr);

endmodule

// File: rtl/datapath2_seq_ctrl.sv
// Load/compute sequencer for the 3-register datapath. Optional build macro
// CARRY_STOP_EN ends a run early on adder carry-out and flags it on ovf.
//
// state | meaning
// IDLE  | waiting for start; step/ovf keep last run's result
// LOAD  | one cycle, datapath loads M0..M2 into all registers
// RUN   | one register written per non-held cycle, in rotation
// DONE  | one-cycle end-of-run pulse
module datapath2_seq_ctrl
  import datapath2_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  input  logic [CNT_W-1:0] iter_cnt,
  input  logic             cin_cfg,
  input  logic             cout,
  output logic             sw1,
  output logic [2:0]       we,
  output logic             cin,
  output logic [CNT_W-1:0] step,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] iter_q, step_q, step_inc;
  logic             cin_q, ovf_q;
  logic             accept, adv, carry_stop;
  logic [2:0]       ptr_we;

`ifdef CARRY_STOP_EN
  assign carry_stop = cout;
`else
  logic unused_cout;
  assign unused_cout = cout;
  assign carry_stop  = 1'b0;
`endif

  assign step_inc = step_q + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = (iter_q == '0) ? DONE : RUN;
      RUN: begin
        if (!hold) begin
          adv = 1'b1;
          if (step_inc == iter_q || carry_stop) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      iter_q <= '0;
      cin_q  <= 1'b0;
      step_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        iter_q <= iter_cnt;
        cin_q  <= cin_cfg;
        step_q <= '0;
        ovf_q  <= 1'b0;
      end else if (adv) begin
        step_q <= step_inc;
        if (carry_stop) ovf_q <= 1'b1;
      end
    end
  end

  datapath2_seq_ctrl_rot3_ptr u_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .adv    (adv),
    .onehot (ptr_we)
  );

  // Outputs decode from registered state; only the RUN write gate follows hold.
  always_comb begin
    sw1  = 1'b0;
    we   = WE_NONE;
    cin  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      LOAD: begin
        sw1  = 1'b1;
        we   = WE_ALL;
        busy = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
        cin  = cin_q;
        if (!hold) we = ptr_we;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign step = step_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_datapath2_seq_ctrl.sv
// Bench for datapath2_seq_ctrl: directed and randomized runs checked cycle by
// cycle against a per-run expected schedule built from the run parameters.
module tb_datapath2_seq_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, hold, cin_cfg, cout;
  logic [CNT_W-1:0] iter_cnt;
  logic             sw1, cin, busy, done, ovf;
  logic [2:0]       we;
  logic [CNT_W-1:0] step;

  int checks   = 0;
  int failures = 0;

  int               h_arr[16];
  bit               c_arr[16];
  logic [CNT_W-1:0] last_step;
  logic             last_ovf;

  logic [11:0] obs;
  assign obs = {sw1, we, cin, step, busy, done, ovf};

  always #5 clk = ~clk;

  datapath2_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .hold     (hold),
    .iter_cnt (iter_cnt),
    .cin_cfg  (cin_cfg),
    .cout     (cout),
    .sw1      (sw1),
    .we       (we),
    .cin      (cin),
    .step     (step),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  function automatic logic [11:0] pk(input logic s, input logic [2:0] w, input logic c,
                                     input logic [CNT_W-1:0] st, input logic b,
                                     input logic d, input logic o);
    return {s, w, c, st, b, d, o};
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%03h exp=%03h (sw1,we,cin,step,busy,done,ovf)", tag, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 16; i++) begin
      h_arr[i] = 0;
      c_arr[i] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      start = 1'b0; hold = 1'($urandom); cout = 1'($urandom);
      iter_cnt = CNT_W'($urandom); cin_cfg = 1'($urandom);
      @(negedge clk);
      check("idle_gap", pk(1'b0, 3'b000, 1'b0, last_step, 1'b0, 1'b0, last_ovf));
      @(posedge clk); #1;
    end
  endtask

  // One run: IDLE accept cycle, LOAD, writes (with scheduled holds), DONE.
  task automatic run(input int iter, input logic ccin, input bit keep_start, input int abort_at);
    int         final_step;
    logic       exp_ovf;
    logic [2:0] wexp;
    start = 1'b1; iter_cnt = CNT_W'(iter); cin_cfg = ccin;
    hold = 1'($urandom); cout = 1'($urandom);
    @(negedge clk);
    check($sformatf("idle_it%0d", iter), pk(1'b0, 3'b000, 1'b0, last_step, 1'b0, 1'b0, last_ovf));
    @(posedge clk); #1;
    start = 1'($urandom); iter_cnt = CNT_W'($urandom); cin_cfg = 1'($urandom);
    hold = 1'($urandom); cout = 1'($urandom);
    @(negedge clk);
    check("load", pk(1'b1, 3'b111, 1'b0, '0, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #1;
    final_step = iter;
    exp_ovf    = 1'b0;
    for (int i = 0; i < iter; i++) begin
      wexp = 3'b001 << (i % 3);
      for (int k = 0; k < h_arr[i]; k++) begin
        hold = 1'b1; start = 1'($urandom); cout = 1'($urandom);
        iter_cnt = CNT_W'($urandom);
        @(negedge clk);
        check($sformatf("hold_w%0d", i), pk(1'b0, 3'b000, ccin, CNT_W'(i), 1'b1, 1'b0, 1'b0));
        @(posedge clk); #1;
      end
      if (i == abort_at) begin
        hold = 1'b0; cout = 1'b0;
        @(negedge clk);
        check("pre_abort", pk(1'b0, wexp, ccin, CNT_W'(i), 1'b1, 1'b0, 1'b0));
        rst_n = 1'b0; start = 1'b0;
        #1;
        check("abort_now", pk(1'b0, 3'b000, 1'b0, '0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        check("abort_hold", pk(1'b0, 3'b000, 1'b0, '0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_step = '0;
        last_ovf  = 1'b0;
        return;
      end
      hold = 1'b0; cout = c_arr[i]; start = 1'($urandom);
      @(negedge clk);
      check($sformatf("write%0d", i), pk(1'b0, wexp, ccin, CNT_W'(i), 1'b1, 1'b0, 1'b0));
      @(posedge clk); #1;
`ifdef CARRY_STOP_EN
      if (c_arr[i]) begin
        final_step = i + 1;
        exp_ovf    = 1'b1;
        break;
      end
`endif
    end
    start = keep_start; hold = 1'($urandom); cout = 1'($urandom);
    @(negedge clk);
    check($sformatf("done_it%0d", iter), pk(1'b0, 3'b000, 1'b0, CNT_W'(final_step), 1'b0, 1'b1, exp_ovf));
    @(posedge clk); #1;
    last_step = CNT_W'(final_step);
    last_ovf  = exp_ovf;
  endtask

  initial begin
    int it;
    rst_n = 1'b0; start = 1'b1; hold = 1'b0; cout = 1'b0;
    iter_cnt = 4'd5; cin_cfg = 1'b1;
    last_step = '0; last_ovf = 1'b0;
    clear_sched();

    // reset held with start high: everything quiet
    @(negedge clk);
    check("reset", pk(1'b0, 3'b000, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    check("reset_edge", pk(1'b0, 3'b000, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;

    run(5, 1'b1, 1'b0, -1);
    idle(1);
    run(0, 1'b1, 1'b0, -1);
    idle(2);

    clear_sched();
    h_arr[1] = 2;
    run(4, 1'b0, 1'b0, -1);

    clear_sched();
    run(2, 1'b1, 1'b1, -1);
    run(2, 1'b0, 1'b1, -1);
    run(3, 1'b1, 1'b0, -1);
    idle(1);

    clear_sched();
    run(9, 1'b1, 1'b0, 3);
    idle(1);

    clear_sched();
    c_arr[2] = 1'b1;
    run(9, 1'b0, 1'b0, -1);
    idle(1);

    run(15, 1'b1, 1'b0, -1);

    for (int r = 0; r < 24; r++) begin
      it = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        h_arr[i] = int'($urandom_range(0, 2));
        c_arr[i] = ($urandom_range(0, 3) == 0);
      end
      run(it, 1'($urandom), 1'($urandom), -1);
      idle(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
